// File: rtl/aes_pkg.sv
// Shared constants and GF(2^8) helpers for the AES encryption core.
package aes_pkg;

  // key_len encodings; 2'b00 is reserved/invalid
  localparam logic [1:0] KL_128 = 2'b01;
  localparam logic [1:0] KL_192 = 2'b10;
  localparam logic [1:0] KL_256 = 2'b11;

  // Round counts (Nr) per key size
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_ROUND = 2'd2
  } aes_state_e;

  // Multiply by x modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) product, shift-and-add over the bits of b
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // Forward S-box: multiplicative inverse (a^254, with 0 -> 0) then the affine map.
  // Computed rather than tabulated so the table cannot carry a typo.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] inv;
    p   = a;
    inv = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p   = gf_mul(p, p);
      inv = gf_mul(inv, p);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Round count for a (valid) key_len encoding
  function automatic logic [3:0] nr_for(input logic [1:0] kl);
    case (kl)
      KL_192:  return NR_192;
      KL_256:  return NR_256;
      default: return NR_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] state_out
);

  logic [127:0] sub_flat;
  logic [127:0] shift_flat;
  logic [127:0] mix_flat;

  genvar gi, gr;
  generate
    // Byte k lives at [127-8k -: 8]; substitute every byte independently
    for (gi = 0; gi < 16; gi++) begin : g_sub
      assign sub_flat[127-8*gi -: 8] = sbox(state_in[127-8*gi -: 8]);
    end

    for (gi = 0; gi < 4; gi++) begin : g_col
      // Row r of column c takes the byte from column (c+r) mod 4
      for (gr = 0; gr < 4; gr++) begin : g_row
        assign shift_flat[127-8*(4*gi+gr) -: 8] = sub_flat[127-8*(4*((gi+gr)%4)+gr) -: 8];
      end

      // {02,03,01,01} circulant on this column; 03*a = xtime(a)^a
      logic [7:0] a0, a1, a2, a3;
      assign a0 = shift_flat[127-32*gi -: 8];
      assign a1 = shift_flat[119-32*gi -: 8];
      assign a2 = shift_flat[111-32*gi -: 8];
      assign a3 = shift_flat[103-32*gi -: 8];
      assign mix_flat[127-32*gi -: 8] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
      assign mix_flat[119-32*gi -: 8] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
      assign mix_flat[111-32*gi -: 8] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
      assign mix_flat[103-32*gi -: 8] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    end
  endgenerate

  // Last round skips MixColumns
  assign state_out = (final_round ? shift_flat : mix_flat) ^ round_key;

endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES-128/192/256 encryption core; one round per accepted subkey, keys fetched 0..Nr.
module aes_encrypt_core
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   key_len,
  output logic         ready,
  input  logic [127:0] plaintext,
  output logic [127:0] ciphertext,
  output logic         done,
  input  logic [127:0] subkey,
  input  logic         subkey_valid,
  output logic [3:0]   subkey_addr
);

  aes_state_e   fsm_reg, fsm_next;
  logic [127:0] state_reg, state_next;
  logic [127:0] ct_reg, ct_next;
  logic [3:0]   nr_reg, nr_next;
  logic [3:0]   addr_reg, addr_next;
  logic         ready_reg, ready_next;
  logic         done_reg, done_next;

  logic [127:0] round_out;
  logic         final_round;

  // The round with subkey index Nr is the last one
  assign final_round = (addr_reg == nr_reg);

  aes_enc_round u_round (
    .state_in    (state_reg),
    .round_key   (subkey),
    .final_round (final_round),
    .state_out   (round_out)
  );

  assign ready       = ready_reg;
  assign done        = done_reg;
  assign ciphertext  = ct_reg;
  assign subkey_addr = addr_reg;

  // State registers; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_reg   <= ST_IDLE;
      state_reg <= '0;
      ct_reg    <= '0;
      nr_reg    <= NR_128;
      addr_reg  <= '0;
      ready_reg <= 1'b1;
      done_reg  <= 1'b0;
    end else begin
      fsm_reg   <= fsm_next;
      state_reg <= state_next;
      ct_reg    <= ct_next;
      nr_reg    <= nr_next;
      addr_reg  <= addr_next;
      ready_reg <= ready_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic: accept, initial AddRoundKey, then one round per valid subkey
  always_comb begin
    fsm_next   = fsm_reg;
    state_next = state_reg;
    ct_next    = ct_reg;
    nr_next    = nr_reg;
    addr_next  = addr_reg;
    ready_next = ready_reg;
    done_next  = 1'b0;

    case (fsm_reg)
      ST_IDLE: begin
        if (start && (key_len != 2'b00)) begin
          state_next = plaintext;
          nr_next    = nr_for(key_len);
          ready_next = 1'b0;
          addr_next  = 4'd0;
          fsm_next   = ST_INIT;
        end
      end

      ST_INIT: begin
        if (subkey_valid) begin
          state_next = state_reg ^ subkey;
          addr_next  = 4'd1;
          fsm_next   = ST_ROUND;
        end
      end

      ST_ROUND: begin
        if (subkey_valid) begin
          if (final_round) begin
            // Only the finished block ever reaches the output register
            ct_next    = round_out;
            ready_next = 1'b1;
            done_next  = 1'b1;
            addr_next  = 4'd0;
            fsm_next   = ST_IDLE;
          end else begin
            state_next = round_out;
            addr_next  = addr_reg + 4'd1;
          end
        end
      end

      default: begin
        fsm_next   = ST_IDLE;
        ready_next = 1'b1;
        addr_next  = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Self-checking bench for aes_encrypt_core: FIPS-197 vectors plus random blocks against a byte-level model.
module tb_aes_encrypt_core;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   key_len;
  logic         ready;
  logic [127:0] plaintext;
  logic [127:0] ciphertext;
  logic         done;
  logic [127:0] subkey;
  logic         subkey_valid;
  logic [3:0]   subkey_addr;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [127:0] rk [0:15];
  logic [127:0] last_ct;
  string        cur_tag;

  logic [7:0] sbox_tab [0:255] = '{
    'h63,'h7c,'h77,'h7b,'hf2,'h6b,'h6f,'hc5,'h30,'h01,'h67,'h2b,'hfe,'hd7,'hab,'h76,
    'hca,'h82,'hc9,'h7d,'hfa,'h59,'h47,'hf0,'had,'hd4,'ha2,'haf,'h9c,'ha4,'h72,'hc0,
    'hb7,'hfd,'h93,'h26,'h36,'h3f,'hf7,'hcc,'h34,'ha5,'he5,'hf1,'h71,'hd8,'h31,'h15,
    'h04,'hc7,'h23,'hc3,'h18,'h96,'h05,'h9a,'h07,'h12,'h80,'he2,'heb,'h27,'hb2,'h75,
    'h09,'h83,'h2c,'h1a,'h1b,'h6e,'h5a,'ha0,'h52,'h3b,'hd6,'hb3,'h29,'he3,'h2f,'h84,
    'h53,'hd1,'h00,'hed,'h20,'hfc,'hb1,'h5b,'h6a,'hcb,'hbe,'h39,'h4a,'h4c,'h58,'hcf,
    'hd0,'hef,'haa,'hfb,'h43,'h4d,'h33,'h85,'h45,'hf9,'h02,'h7f,'h50,'h3c,'h9f,'ha8,
    'h51,'ha3,'h40,'h8f,'h92,'h9d,'h38,'hf5,'hbc,'hb6,'hda,'h21,'h10,'hff,'hf3,'hd2,
    'hcd,'h0c,'h13,'hec,'h5f,'h97,'h44,'h17,'hc4,'ha7,'h7e,'h3d,'h64,'h5d,'h19,'h73,
    'h60,'h81,'h4f,'hdc,'h22,'h2a,'h90,'h88,'h46,'hee,'hb8,'h14,'hde,'h5e,'h0b,'hdb,
    'he0,'h32,'h3a,'h0a,'h49,'h06,'h24,'h5c,'hc2,'hd3,'hac,'h62,'h91,'h95,'he4,'h79,
    'he7,'hc8,'h37,'h6d,'h8d,'hd5,'h4e,'ha9,'h6c,'h56,'hf4,'hea,'h65,'h7a,'hae,'h08,
    'hba,'h78,'h25,'h2e,'h1c,'ha6,'hb4,'hc6,'he8,'hdd,'h74,'h1f,'h4b,'hbd,'h8b,'h8a,
    'h70,'h3e,'hb5,'h66,'h48,'h03,'hf6,'h0e,'h61,'h35,'h57,'hb9,'h86,'hc1,'h1d,'h9e,
    'he1,'hf8,'h98,'h11,'h69,'hd9,'h8e,'h94,'h9b,'h1e,'h87,'he9,'hce,'h55,'h28,'hdf,
    'h8c,'ha1,'h89,'h0d,'hbf,'he6,'h42,'h68,'h41,'h99,'h2d,'h0f,'hb0,'h54,'hbb,'h16
  };

  always #5 clk = ~clk;

  // Subkey store answers whatever index the core requests
  assign subkey = rk[subkey_addr];

  aes_encrypt_core dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .key_len      (key_len),
    .ready        (ready),
    .plaintext    (plaintext),
    .ciphertext   (ciphertext),
    .done         (done),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_addr  (subkey_addr)
  );

  task automatic chk(input string name, input bit ok, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $error("FAIL %s/%s: observed %0h expected %0h", cur_tag, name, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int p, x, y;
    p = 0; x = int'(a); y = int'(b);
    while (y != 0) begin
      if ((y & 1) != 0) p = p ^ x;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11b;
      y = y >> 1;
    end
    return p[7:0];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
  endfunction

  // Word-oriented key schedule; key is left-aligned in 256 bits, nk words long
  task automatic expand_key(input logic [255:0] key, input int nk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon;
    int          nr;
    nr   = nk + 6;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  // Byte-array cipher over the currently expanded round keys
  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input int nr);
    logic [7:0]   s [0:15];
    logic [7:0]   t [0:15];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ rk[0][127-8*k -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int k = 0; k < 16; k++) t[k] = sbox_tab[s[k]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          s[4*c+row] = t[4*((c+row)%4)+row];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
          s[4*c+3] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
        end
      end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk[r][127-8*k -: 8];
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  function automatic logic [1:0] kl_of(input int nk);
    return (nk == 4) ? 2'b01 : (nk == 6) ? 2'b10 : 2'b11;
  endfunction

  // One encryption starting at the current negedge (round keys already loaded).
  task automatic run_op(input int nk, input logic [127:0] pt, input logic [127:0] exp_ct,
                        input bit stall, input bit disturb, input int abort_at, input string tag);
    int         nr, k;
    bit         finished;
    logic [3:0] exp_addr;
    logic       exp_ready, exp_done;
    cur_tag  = tag;
    nr       = nk + 6;
    k        = 0;
    finished = 1'b0;
    chk("ready_at_start", ready === 1'b1, ready, 1'b1);
    plaintext    = pt;
    key_len      = kl_of(nk);
    start        = 1'b1;
    subkey_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      exp_addr  = (k <= nr) ? 4'(k) : 4'd0;
      exp_ready = (k > nr);
      exp_done  = (k == nr + 1);
      chk("subkey_addr", subkey_addr === exp_addr, subkey_addr, exp_addr);
      chk("ready", ready === exp_ready, ready, exp_ready);
      chk("done", done === exp_done, done, exp_done);
      if (abort_at > 0 && k == abort_at) begin
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("rst_ready", ready === 1'b1, ready, 1'b1);
        chk("rst_ct", ciphertext === 128'h0, ciphertext, 128'h0);
        chk("rst_addr", subkey_addr === 4'd0, subkey_addr, 4'd0);
        chk("rst_done", done === 1'b0, done, 1'b0);
        reset    = 1'b0;
        last_ct  = 128'h0;
        finished = 1'b1;
      end else if (k == nr + 1) begin
        chk("ciphertext", ciphertext === exp_ct, ciphertext, exp_ct);
        if (!stall) chk("latency", cyc === nr + 1, cyc, nr + 1);
        last_ct  = exp_ct;
        finished = 1'b1;
        $display("[TB] %s nr=%0d ct=%032h cycles=%0d", tag, nr, ciphertext, cyc);
      end else begin
        chk("ct_hold", ciphertext === last_ct, ciphertext, last_ct);
        start = disturb && (k == 3 || k == 4);
        if (disturb) begin
          plaintext = {$urandom, $urandom, $urandom, $urandom};
          key_len   = 2'($urandom_range(0, 3));
        end
        subkey_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        if (subkey_valid) k++;
      end
    end
    chk("timeout", finished === 1'b1, finished, 1'b1);
  endtask

  // Absolute guard against a hang
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K_128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K_192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K_256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial begin
    logic [255:0] rkey;
    logic [127:0] rpt, rexp;
    int           nk;

    reset        = 1'b1;
    start        = 1'b0;
    key_len      = 2'b00;
    plaintext    = '0;
    subkey_valid = 1'b0;
    last_ct      = '0;
    cur_tag      = "reset";
    for (int i = 0; i < 16; i++) rk[i] = '0;
    repeat (3) @(negedge clk);
    chk("ready", ready === 1'b1, ready, 1'b1);
    chk("ciphertext", ciphertext === 128'h0, ciphertext, 128'h0);
    chk("done", done === 1'b0, done, 1'b0);
    chk("subkey_addr", subkey_addr === 4'd0, subkey_addr, 4'd0);
    reset = 1'b0;
    @(negedge clk);

    // FIPS-197 C.1 / C.2 / C.3, each started in the previous done cycle
    expand_key(K_128, 4);
    run_op(4, PT_C, CT_128, 1'b0, 1'b0, 0, "c1_aes128");
    expand_key(K_192, 6);
    run_op(6, PT_C, CT_192, 1'b0, 1'b0, 0, "c2_aes192_b2b");
    expand_key(K_256, 8);
    run_op(8, PT_C, CT_256, 1'b0, 1'b0, 0, "c3_aes256_b2b");

    // Invalid key_len is ignored
    cur_tag   = "kl00";
    key_len   = 2'b00;
    plaintext = {$urandom, $urandom, $urandom, $urandom};
    start     = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("ready", ready === 1'b1, ready, 1'b1);
      chk("done", done === 1'b0, done, 1'b0);
      chk("subkey_addr", subkey_addr === 4'd0, subkey_addr, 4'd0);
      chk("ct_hold", ciphertext === last_ct, ciphertext, last_ct);
    end
    start = 1'b0;
    $display("[TB] kl00 start ignored");
    @(negedge clk);

    // Start/plaintext/key_len toggled mid-operation
    expand_key(K_128, 4);
    run_op(4, PT_C, CT_128, 1'b0, 1'b1, 0, "c1_disturbed");
    @(negedge clk);

    // Reset during round 5, then a clean run
    run_op(4, PT_C, CT_128, 1'b0, 1'b0, 5, "c1_abort");
    $display("[TB] c1_abort reset state checked");
    @(negedge clk);
    run_op(4, PT_C, CT_128, 1'b0, 1'b0, 0, "c1_after_reset");
    @(negedge clk);

    // FIPS-197 Appendix B with ~50% subkey stalls
    expand_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
    run_op(4, 128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32,
           1'b1, 1'b0, 0, "appb_stall");
    @(negedge clk);

    // Random keys, sizes and blocks against the model
    for (int i = 0; i < 8; i++) begin
      nk   = 4 + 2 * int'($urandom_range(0, 2));
      rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      rpt  = {$urandom, $urandom, $urandom, $urandom};
      expand_key(rkey, nk);
      rexp = ref_encrypt(rpt, nk + 6);
      run_op(nk, rpt, rexp, (i % 2) == 1, 1'b0, 0, "random");
      if (i % 3 == 0) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
